tt_um_dev_latch_bank: RTL

//  Parametrised successor to the single-bit D latch: a DEPTH x WIDTH clocked storage bank.

---
 rtl/tt_um_dev_latch_bank_if.sv | 19 +
 rtl/tt_um_dev_latch_bank.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/tt_um_dev_latch_bank_if.sv
// Pin bundle for the latch bank: TT user-slot byte lanes.
// master drives ui_in/uio_in, slave drives uo_out/uio_out/uio_oe.
interface tt_um_dev_latch_bank_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_dev_latch_bank.sv
// DEPTH x WIDTH clocked storage bank: latch/dff/toggle/shift modes + clear sweep.
// Ports: clk, rst_n (async low), ena (ignored), bus (ui_in/uio_in in, uo_out/uio_out/uio_oe out).
module tt_um_dev_latch_bank #(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  tt_um_dev_latch_bank_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PW     = WIDTH + ADDR_W + 4;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  // Every pin field goes through the same chain so they stay aligned.
  logic [PW-1:0] pin;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] s;

  assign pin = {bus.uio_in[1:0],
                bus.ui_in[7],
                bus.ui_in[6],
                bus.ui_in[4 +: ADDR_W],
                bus.ui_in[WIDTH-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pin;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  logic [WIDTH-1:0]  d_s;
  logic [ADDR_W-1:0] addr_s;
  logic              en_s;
  logic              clr_s;
  logic [1:0]        mode_s;

  assign d_s    = s[WIDTH-1:0];
  assign addr_s = s[WIDTH +: ADDR_W];
  assign en_s   = s[WIDTH+ADDR_W];
  assign clr_s  = s[WIDTH+ADDR_W+1];
  assign mode_s = s[PW-1 -: 2];

  logic en_d1_q;
  logic clr_d1_q;
  logic en_rise;
  logic clr_rise;

  assign en_rise  = en_s & ~en_d1_q;
  assign clr_rise = clr_s & ~clr_d1_q;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [7:0]        uo_q, uo_d;

  logic busy;
  logic clr_go;

  assign busy   = (state_q == S_CLEAR);
  // A clr_rise during the sweep is ignored.
  assign clr_go = clr_rise & ~busy;

  always_comb begin
    mem_d   = mem_q;
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (1'b1)
      busy: begin
        mem_d[ptr_q] = '0;
        ptr_d        = ptr_q + 1'b1;
        if (ptr_q == LAST) begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end
      end
      // Clear wins over a coincident write.
      clr_go: begin
        state_d = S_CLEAR;
        ptr_d   = '0;
      end
      default: begin
        unique case (mode_s)
          2'b00: if (en_s) mem_d[addr_s] = d_s;
          2'b01: if (en_rise) mem_d[addr_s] = d_s;
          2'b10: if (en_rise) mem_d[addr_s] = mem_q[addr_s] ^ d_s;
          2'b11: begin
            if (en_rise) begin
              for (int i = DEPTH - 1; i > 0; i--)
                mem_d[i] = mem_q[i-1];
              mem_d[0] = d_s;
            end
          end
        endcase
      end
    endcase
  end

  always_comb begin
    uo_d              = '0;
    uo_d[WIDTH-1:0]   = mem_q[addr_s];
    uo_d[4]           = busy;
    uo_d[5]           = en_s;
    uo_d[7:6]         = mode_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_d1_q  <= 1'b0;
      clr_d1_q <= 1'b0;
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      uo_q     <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      en_d1_q  <= en_s;
      clr_d1_q <= clr_s;
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      uo_q     <= uo_d;
      mem_q    <= mem_d;
    end
  end

  assign bus.uo_out  = uo_q;
  assign bus.uio_out = '0;
  assign bus.uio_oe  = '0;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, bus.ui_in, bus.uio_in};

endmodule
